// File: rtl/jump_sequencer.sv
// Program-counter sequencer: fetch, wait for ALU result, evaluate lt/eq/gt jump, pick next PC.
// Optional performance counters are compiled in with JUMP_SEQ_PERF_EN.
module jump_sequencer #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    fetch_req,
   output logic [WIDTH-1:0]        fetch_addr,
   input  logic                    fetch_ack,
   input  logic                    exec_valid,
   input  logic [2:0]              cond,
   input  logic signed [WIDTH-1:0] x,
   input  logic [WIDTH-1:0]        target,
   output logic [WIDTH-1:0]        pc,
   output logic                    jump_taken,
   output logic                    busy,
   output logic                    halted
`ifdef JUMP_SEQ_PERF_EN
   ,
   output logic [15:0]             retired_count,
   output logic [15:0]             jump_count
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   logic [1:0] state;
   logic       taken;
   logic       retire;
   logic       halt_idiom;

   // Sign and zero tests done on bits so the compare can never silently go unsigned.
   function automatic logic eval_taken(input logic [2:0] c, input logic signed [WIDTH-1:0] v);
      logic neg, zero, pos;
      neg  = v[WIDTH-1];
      zero = (v == {WIDTH{1'b0}});
      pos  = !neg && !zero;
      return (c[2] & neg) | (c[1] & zero) | (c[0] & pos);
   endfunction

   assign taken      = eval_taken(cond, x);
   assign retire     = (state == ST_EXEC) && exec_valid;
   assign halt_idiom = (cond == 3'b111) && (target == pc);

   assign fetch_req  = (state == ST_FETCH);
   assign fetch_addr = pc;
   assign busy       = (state == ST_FETCH) || (state == ST_EXEC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         jump_taken <= 1'b0;
         halted     <= 1'b0;
      end else begin
         jump_taken <= 1'b0;
         case (state)
            ST_IDLE:  if (start) state <= ST_FETCH;
            ST_FETCH: if (fetch_ack) state <= ST_EXEC;
            ST_EXEC: begin
               if (exec_valid) begin
                  // Unconditional jump to self is the halt idiom; pc stays put.
                  if (halt_idiom) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     pc         <= taken ? target : pc + WIDTH'(1);
                     jump_taken <= taken;
                     state      <= ST_FETCH;
                  end
               end
            end
            ST_HALT:  state <= ST_HALT;
            default:  state <= ST_IDLE;
         endcase
      end
   end

`ifdef JUMP_SEQ_PERF_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_count <= 16'd0;
         jump_count    <= 16'd0;
      end else if (retire) begin
         retired_count <= sat_inc(retired_count);
         if (taken) jump_count <= sat_inc(jump_count);
      end
   end
`endif

endmodule

// File: tb/tb_jump_sequencer.sv
// Self-checking bench for jump_sequencer: vector table, hand sequences, randomized run vs. a transaction model.
module tb_jump_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ack = 1'b0;
   logic        exec_valid = 1'b0;
   logic [2:0]  cond_i = 3'b000;
   logic [15:0] x_i = 16'h0;
   logic [15:0] target_i = 16'h0;
   logic [15:0] pc;
   logic        jump_taken;
   logic        busy;
   logic        halted;
`ifdef JUMP_SEQ_PERF_EN
   logic [15:0] retired_count;
   logic [15:0] jump_count;
`endif

   jump_sequencer #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
      .exec_valid(exec_valid), .cond(cond_i), .x(x_i), .target(target_i),
      .pc(pc), .jump_taken(jump_taken), .busy(busy), .halted(halted)
`ifdef JUMP_SEQ_PERF_EN
      , .retired_count(retired_count), .jump_count(jump_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Transaction-level model: architectural PC, halt flag and retirement tallies.
   logic [15:0] mpc;
   bit          mhalt;
   int          mret;
   int          mjmp;

   typedef struct {
      logic [15:0] pc_set;
      logic [2:0]  c;
      logic [15:0] x;
      logic [15:0] tgt;
      logic [15:0] exp_pc;
      logic        exp_j;
      logic        exp_h;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_taken(input bit [2:0] c, input bit [15:0] v);
      int s;
      s = $signed(v);
      return (c[2] && s < 0) || (c[1] && s == 0) || (c[0] && s > 0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; fetch_ack = 1'b0; exec_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      mpc = 16'h0000; mhalt = 0; mret = 0; mjmp = 0;
      chk("rst pc", pc, 16'h0000);
      chk("rst fetch_req", fetch_req, 0);
      chk("rst busy", busy, 0);
      chk("rst halted", halted, 0);
      chk("rst jump_taken", jump_taken, 0);
`ifdef JUMP_SEQ_PERF_EN
      chk("rst retired_count", retired_count, 0);
      chk("rst jump_count", jump_count, 0);
`endif
   endtask

   task automatic do_start();
      chk("idle fetch_req", fetch_req, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start latency fetch_req", fetch_req, 1);
      chk("start fetch_addr", fetch_addr, mpc);
   endtask

   // Entered with the DUT in its first FETCH cycle; leaves it in FETCH or HALT.
   task automatic do_instr(input logic [2:0] c, input logic [15:0] xv, input logic [15:0] tgt,
                           input int ack_dly, input int exec_dly, input bit noise);
      bit t;
      fetch_ack = 1'b0;
      exec_valid = noise;
      cond_i = 3'b111; x_i = 16'h0; target_i = mpc + 16'd5;
      for (int k = 0; k < ack_dly; k++) begin
         chk("fetch hold req", fetch_req, 1);
         chk("fetch hold addr", fetch_addr, mpc);
         tick();
         chk("fetch jump_taken low", jump_taken, 0);
         chk("fetch pc stable", pc, mpc);
      end
      fetch_ack = 1'b1;
      chk("ack req", fetch_req, 1);
      chk("ack addr", fetch_addr, mpc);
      tick();
      fetch_ack = 1'b0; exec_valid = 1'b0;
      chk("exec req low", fetch_req, 0);
      chk("exec busy", busy, 1);
      chk("exec jump_taken low", jump_taken, 0);
      chk("exec pc", pc, mpc);
      cond_i = c; x_i = xv; target_i = tgt;
      for (int k = 0; k < exec_dly; k++) begin
         fetch_ack = 1'($urandom_range(0, 1));
         tick();
         chk("exec wait req", fetch_req, 0);
         chk("exec wait pc", pc, mpc);
      end
      fetch_ack = 1'b0;
      exec_valid = 1'b1;
      tick();
      exec_valid = 1'b0;
      t = ref_taken(c, xv);
      mret++;
      if (t) mjmp++;
      if (c == 3'b111 && tgt == mpc) begin
         mhalt = 1;
         chk("halt halted", halted, 1);
         chk("halt busy", busy, 0);
         chk("halt req", fetch_req, 0);
         chk("halt pc", pc, mpc);
         chk("halt jump_taken", jump_taken, 0);
      end else begin
         mpc = t ? tgt : mpc + 16'd1;
         chk("retire pc", pc, mpc);
         chk("retire jump_taken", jump_taken, t);
         chk("retire req", fetch_req, 1);
         chk("retire halted", halted, 0);
      end
`ifdef JUMP_SEQ_PERF_EN
      chk("retired_count", retired_count, (mret > 65535) ? 65535 : mret);
      chk("jump_count", jump_count, (mjmp > 65535) ? 65535 : mjmp);
`endif
   endtask

   task automatic halt_hold();
      for (int k = 0; k < 4; k++) begin
         start = 1'b1; fetch_ack = 1'($urandom_range(0, 1)); exec_valid = 1'b1;
         tick();
         chk("halt hold halted", halted, 1);
         chk("halt hold busy", busy, 0);
         chk("halt hold req", fetch_req, 0);
         chk("halt hold pc", pc, mpc);
         chk("halt hold jump_taken", jump_taken, 0);
      end
      start = 1'b0; fetch_ack = 1'b0; exec_valid = 1'b0;
   endtask

   function automatic logic [15:0] rand_x();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'h8000;
         2: return 16'h7FFF;
         3: return 16'hFFFF;
         4: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      //            pc_set    c       x         tgt       exp_pc    j  h
      vecs[0]  = '{16'h0003, 3'b001, 16'h0001, 16'h0040, 16'h0040, 1, 0};
      vecs[1]  = '{16'h0003, 3'b001, 16'hFFFF, 16'h0040, 16'h0004, 0, 0};
      vecs[2]  = '{16'hFFFF, 3'b000, 16'h0005, 16'h0000, 16'h0000, 0, 0};
      vecs[3]  = '{16'h0005, 3'b100, 16'h8000, 16'h1234, 16'h1234, 1, 0};
      vecs[4]  = '{16'h0005, 3'b010, 16'h0000, 16'h0009, 16'h0009, 1, 0};
      vecs[5]  = '{16'h0005, 3'b010, 16'h0001, 16'h0009, 16'h0006, 0, 0};
      vecs[6]  = '{16'h0005, 3'b111, 16'h0000, 16'h0005, 16'h0005, 0, 1};
      vecs[7]  = '{16'h000A, 3'b010, 16'h0000, 16'h000A, 16'h000A, 1, 0};
      vecs[8]  = '{16'h000A, 3'b101, 16'h0000, 16'h000A, 16'h000B, 0, 0};
      vecs[9]  = '{16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0001, 0, 0};
      vecs[10] = '{16'h0007, 3'b111, 16'h007B, 16'h0007, 16'h0007, 0, 1};
      vecs[11] = '{16'h0020, 3'b110, 16'h7FFF, 16'h0003, 16'h0021, 0, 0};

      do_reset();

      // Straight-line fetches at minimum period: addresses 0,1,2.
      do_start();
      for (int i = 0; i < 3; i++) begin
         chk("seq fetch_addr", fetch_addr, 16'(i));
         do_instr(3'b000, 16'h0005, 16'h0099, 0, 0, 0);
      end
      chk("seq final pc", pc, 16'h0003);

      // Slow ack with exec_valid noise during FETCH.
      do_instr(3'b000, 16'h0005, 16'h0000, 3, 2, 1);
      chk("slow ack pc", pc, 16'h0004);

      foreach (vecs[i]) begin
         do_reset();
         do_start();
         if (vecs[i].pc_set != 16'h0000)
            do_instr(3'b111, 16'h0000, vecs[i].pc_set, 0, 0, 0);
         chk("vec setup pc", pc, vecs[i].pc_set);
         do_instr(vecs[i].c, vecs[i].x, vecs[i].tgt, $urandom_range(0, 2), $urandom_range(0, 2), 0);
         chk("vec pc", pc, vecs[i].exp_pc);
         chk("vec halted", halted, vecs[i].exp_h);
         chk("vec jump_taken", jump_taken, vecs[i].exp_j);
         if (vecs[i].exp_h) halt_hold();
      end

      // Reset arriving mid-EXEC wins over a simultaneous retirement.
      do_reset();
      do_start();
      do_instr(3'b111, 16'h0000, 16'h0020, 0, 0, 0);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      rst_n = 1'b0; exec_valid = 1'b1; cond_i = 3'b111; target_i = 16'h0050;
      tick();
      rst_n = 1'b1; exec_valid = 1'b0;
      mpc = 16'h0000; mhalt = 0; mret = 0; mjmp = 0;
      chk("midreset pc", pc, 16'h0000);
      chk("midreset req", fetch_req, 0);
      chk("midreset busy", busy, 0);
      chk("midreset halted", halted, 0);
      chk("midreset jump_taken", jump_taken, 0);
      tick();
      chk("midreset stays idle", fetch_req, 0);

      // Randomized run against the model.
      do_start();
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  c;
         logic [15:0] tv;
         c  = 3'($urandom_range(0, 7));
         tv = ($urandom_range(0, 9) == 0) ? mpc : 16'($urandom);
         do_instr(c, rand_x(), tv, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         if (mhalt) begin
            halt_hold();
            do_reset();
            do_start();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
